// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative MULT/MULTU/DIV/DIVU sequencer driving an external ALU
// Shift-add multiply and restoring divide, 32 iterations, HI/LO written in FIXUP.
module muldiv_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] alu_op_1,
  output logic [31:0] alu_op_2,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_res,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        divz
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  state_t state, state_next;

  // acc holds P_hi (multiply) or R (divide); qr holds P_lo or Q; m holds M or D.
  logic        div_mode;
  logic        neg_q;
  logic        neg_r;
  logic [4:0]  cnt;
  logic [31:0] acc;
  logic [31:0] qr;
  logic [31:0] m;

  logic        signed_in;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;

  assign signed_in = ~op[0];
  assign rs_mag    = (signed_in && rs_val[31]) ? -rs_val : rs_val;
  assign rt_mag    = (signed_in && rt_val[31]) ? -rt_val : rt_val;

  logic        div_t;
  logic [31:0] div_sh;
  logic        div_take;
  logic        mul_carry;

  assign {div_t, div_sh} = {acc, qr[31]};
  assign div_take        = div_t | (div_sh >= m);
  assign mul_carry       = (alu_res < acc);

  logic [63:0] prod;
  logic [63:0] prod_neg;
  logic [31:0] q_neg;
  logic [31:0] r_neg;

  assign prod     = {acc, qr};
  assign prod_neg = -prod;
  assign q_neg    = -qr;
  assign r_neg    = -acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    alu_op_1   = 32'd0;
    alu_op_2   = 32'd0;
    alu_ctrl   = ALU_ADD;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (div_mode) begin
          alu_op_1 = div_sh;
          alu_op_2 = m;
          alu_ctrl = ALU_SUB;
        end else begin
          alu_op_1 = acc;
          alu_op_2 = qr[0] ? m : 32'd0;
        end
        if (cnt == 5'd31) begin
          state_next = FIXUP;
        end
      end
      FIXUP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      divz     <= 1'b0;
      div_mode <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      cnt      <= 5'd0;
      acc      <= 32'd0;
      qr       <= 32'd0;
      m        <= 32'd0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state == FIXUP);
      case (state)
        IDLE: begin
          if (start) begin
            div_mode <= op[1];
            neg_q    <= signed_in & (rs_val[31] ^ rt_val[31]);
            neg_r    <= signed_in & rs_val[31];
            cnt      <= 5'd0;
            acc      <= 32'd0;
            qr       <= rs_mag;
            m        <= rt_mag;
          end
        end
        RUN: begin
          cnt <= cnt + 5'd1;
          if (div_mode) begin
            if (div_take) begin
              acc <= alu_res;
              qr  <= {qr[30:0], 1'b1};
            end else begin
              acc <= div_sh;
              qr  <= {qr[30:0], 1'b0};
            end
          end else begin
            // Carry out of the ALU add becomes the new MSB of the 65-bit shift.
            acc <= {mul_carry, alu_res[31:1]};
            qr  <= {alu_res[0], qr[31:1]};
          end
        end
        FIXUP: begin
          if (div_mode) begin
            lo   <= neg_q ? q_neg : qr;
            hi   <= neg_r ? r_neg : acc;
            divz <= (m == 32'd0);
          end else begin
            {hi, lo} <= neg_q ? prod_neg : prod;
            divz     <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - self-checking bench for muldiv_seq
// Directed cases plus randomized operations against an arithmetic reference model.
module tb_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] alu_op_1;
  logic [31:0] alu_op_2;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_res;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        divz;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  muldiv_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .alu_op_1 (alu_op_1),
    .alu_op_2 (alu_op_2),
    .alu_ctrl (alu_ctrl),
    .alu_res  (alu_res),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .divz     (divz)
  );

  // Shared ALU: ADD or SUB, combinational.
  assign alu_res = (alu_ctrl == 4'b0110) ? (alu_op_1 - alu_op_2) :
                   (alu_ctrl == 4'b0010) ? (alu_op_1 + alu_op_2) : 32'hDEADBEEF;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] eh, output logic [31:0] el, output logic ed);
    longint          sp;
    longint unsigned up;
    logic [31:0]     ma, mb, qm, rm;
    logic            sg, nq, nr;
    ed = 1'b0;
    case (o)
      2'd0: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        {eh, el} = sp;
      end
      2'd1: begin
        up = 64'(a) * 64'(b);
        {eh, el} = up;
      end
      default: begin
        sg = (o == 2'd2);
        ma = (sg && a[31]) ? -a : a;
        mb = (sg && b[31]) ? -b : b;
        nq = sg & (a[31] ^ b[31]);
        nr = sg & a[31];
        if (mb == 32'd0) begin
          qm = 32'hFFFFFFFF;
          rm = ma;
        end else begin
          qm = ma / mb;
          rm = ma % mb;
        end
        el = nq ? -qm : qm;
        eh = nr ? -rm : rm;
        ed = (b == 32'd0);
      end
    endcase
  endtask

  // Caller is at a negedge; leaves at the negedge of cycle 1.
  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
  endtask

  task automatic finish_op(input string tag, input logic [31:0] eh, input logic [31:0] el,
                           input logic ed);
    logic busy_ok;
    busy_ok = 1'b1;
    while (!done && cyc < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk({tag, " busy_run"}, 64'(busy_ok), 64'd1);
    chk({tag, " done_cycle"}, 64'(cyc), 64'd34);
    chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, " hi"}, 64'(hi), 64'(eh));
    chk({tag, " lo"}, 64'(lo), 64'(el));
    chk({tag, " divz"}, 64'(divz), 64'(ed));
  endtask

  logic [31:0] eh, el;
  logic        ed;
  logic        quiet;

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    op     = 2'd0;
    rs_val = 32'd0;
    rt_val = 32'd0;
    #1;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst hi", 64'(hi), 64'd0);
    chk("rst lo", 64'(lo), 64'd0);
    chk("rst divz", 64'(divz), 64'd0);
    chk("rst alu", {alu_op_1, alu_op_2}, 64'd0);
    chk("rst ctrl", 64'(alu_ctrl), 64'h2);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    start_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu run ctrl", 64'(alu_ctrl), 64'h2);
    chk("multu run op2", 64'(alu_op_2), 64'hFFFFFFFF);
    finish_op("multu max", 32'hFFFFFFFE, 32'h00000001, 1'b0);

    @(negedge clk);
    start_op(2'd0, 32'hFFFFFFFD, 32'd7);
    finish_op("mult -3x7", 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);

    @(negedge clk);
    start_op(2'd2, 32'hFFFFFFF9, 32'd2);
    chk("div run ctrl", 64'(alu_ctrl), 64'h6);
    chk("div run op2", 64'(alu_op_2), 64'd2);
    finish_op("div -7/2", 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);

    @(negedge clk);
    start_op(2'd2, 32'h80000000, 32'hFFFFFFFF);
    finish_op("div min/-1", 32'h00000000, 32'h80000000, 1'b0);

    @(negedge clk);
    start_op(2'd3, 32'd5, 32'd0);
    finish_op("divu 5/0", 32'd5, 32'hFFFFFFFF, 1'b1);

    @(negedge clk);
    start_op(2'd1, 32'd6, 32'd7);
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk("divz held", 64'(divz), 64'd1);
    start  = 1'b1;
    op     = 2'd2;
    rs_val = 32'd1000;
    rt_val = 32'd9;
    @(negedge clk);
    cyc++;
    start = 1'b0;
    finish_op("multu 6x7 ignore", 32'd0, 32'd42, 1'b0);

    start_op(2'd2, 32'hFFFFFFF9, 32'd2);
    finish_op("b2b div -7/2", 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);

    @(negedge clk);
    start_op(2'd3, 32'd1000, 32'd3);
    while (cyc < 15) begin
      @(negedge clk);
      cyc++;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort hi", 64'(hi), 64'd0);
    chk("abort lo", 64'(lo), 64'd0);
    quiet = 1'b1;
    repeat (25) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    chk("abort no done", 64'(quiet), 64'd1);
    start_op(2'd3, 32'd100, 32'd7);
    finish_op("divu 100/7", 32'd2, 32'd14, 1'b0);

    for (int i = 0; i < 16; i++) begin
      logic [1:0]  o;
      logic [31:0] a, b;
      int          sel;
      o   = 2'($urandom_range(0, 3));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 5);
      if (sel == 0) b = 32'd0;
      if (sel == 1) b = $urandom_range(1, 9);
      if (sel == 2) a = 32'h80000000;
      ref_model(o, a, b, eh, el, ed);
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      start_op(o, a, b);
      finish_op($sformatf("rand%0d op%0d %h/%h", i, o, a, b), eh, el, ed);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
